// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between vga_timing_ctrl (master) and the video output stage.
// The fetch_* signals exist only when VGA_PREFETCH_EN is defined.
interface vga_timing_ctrl_if #(
  parameter int unsigned CW = 10
);
  logic          enable;
  logic          running;
  logic          h_synch;
  logic          v_synch;
  logic          blank;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_PREFETCH_EN
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;
  logic          fetch_valid;

  modport master (
    input  enable,
    output running, h_synch, v_synch, blank, pixel_x, pixel_y,
    output line_start, frame_start, fetch_x, fetch_y, fetch_valid
  );
  modport slave (
    output enable,
    input  running, h_synch, v_synch, blank, pixel_x, pixel_y,
    input  line_start, frame_start, fetch_x, fetch_y, fetch_valid
  );
`else
  modport master (
    input  enable,
    output running, h_synch, v_synch, blank, pixel_x, pixel_y,
    output line_start, frame_start
  );
  modport slave (
    output enable,
    input  running, h_synch, v_synch, blank, pixel_x, pixel_y,
    input  line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with frame-aligned run/park control; all outputs registered.
// Define VGA_PREFETCH_EN to add fetch_x/fetch_y/fetch_valid one pixel ahead of the display.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned CW          = 10
) (
  input  logic              pixel_clock,
  input  logic              reset,
  vga_timing_ctrl_if.master vga
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {PARKED, RUNNING} state_t;

  state_t        state, state_next;
  logic [CW-1:0] x, y, x_next, y_next;
  logic          run_next, blank_next, hs_next, vs_next, ls_next, fs_next;
  logic          running_q, blank_q, hs_q, vs_q, ls_q, fs_q;

  // Raster successor of (cx, cy), packed as {y, x}.
  function automatic logic [2*CW-1:0] advance(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    logic [CW-1:0] nx, ny;
    nx = (cx == H_LAST) ? '0 : cx + 1'b1;
    ny = cy;
    if (cx == H_LAST) ny = (cy == V_LAST) ? '0 : cy + 1'b1;
    return {ny, nx};
  endfunction

  // Outputs are decoded from the post-edge count so they align with pixel_x/pixel_y.
  always_comb begin
    state_next = state;
    x_next     = H_LAST;
    y_next     = V_LAST;
    case (state)
      PARKED: begin
        if (vga.enable) begin
          state_next = RUNNING;
          x_next     = '0;
          y_next     = '0;
        end
      end
      RUNNING: begin
        if (x == H_LAST && y == V_LAST && !vga.enable) state_next = PARKED;
        else {y_next, x_next} = advance(x, y);
      end
      default: state_next = PARKED;
    endcase

    run_next   = (state_next == RUNNING);
    blank_next = !run_next || (x_next >= H_ACT) || (y_next >= V_ACT);
    hs_next    = (run_next && x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_next    = (run_next && y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    ls_next    = run_next && (x_next == '0);
    fs_next    = ls_next && (y_next == '0);
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state     <= PARKED;
      x         <= H_LAST;
      y         <= V_LAST;
      running_q <= 1'b0;
      blank_q   <= 1'b1;
      hs_q      <= ~SYNC_ACTIVE;
      vs_q      <= ~SYNC_ACTIVE;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      running_q <= run_next;
      blank_q   <= blank_next;
      hs_q      <= hs_next;
      vs_q      <= vs_next;
      ls_q      <= ls_next;
      fs_q      <= fs_next;
    end
  end

  assign vga.running     = running_q;
  assign vga.blank       = blank_q;
  assign vga.h_synch     = hs_q;
  assign vga.v_synch     = vs_q;
  assign vga.pixel_x     = x;
  assign vga.pixel_y     = y;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

`ifdef VGA_PREFETCH_EN
  logic [CW-1:0] fx_next, fy_next, fx_q, fy_q;
  logic          fv_next, fv_q;

  // While parked the fetch sits at (0,0) and is qualified by the run request.
  always_comb begin
    fx_next = '0;
    fy_next = '0;
    fv_next = vga.enable;
    if (run_next) begin
      {fy_next, fx_next} = advance(x_next, y_next);
      fv_next = (fx_next < H_ACT) && (fy_next < V_ACT);
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      fx_q <= '0;
      fy_q <= '0;
      fv_q <= 1'b0;
    end else begin
      fx_q <= fx_next;
      fy_q <= fy_next;
      fv_q <= fv_next;
    end
  end

  assign vga.fetch_x     = fx_q;
  assign vga.fetch_y     = fy_q;
  assign vga.fetch_valid = fv_q;
`endif
endmodule
